// File: rtl/logic_unit_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : logic_unit_pipe_pkg
// Purpose  : Shared op encoding for the pipelined logic unit.
// Revision : 1.0
// ============================================================================
package logic_unit_pipe_pkg;

    typedef logic [2:0] op_t;

    // Codes 000-011 keep the legacy cell mapping: op[0] inverts, op[1] selects OR.
    localparam op_t OP_AND  = 3'b000;
    localparam op_t OP_NAND = 3'b001;
    localparam op_t OP_OR   = 3'b010;
    localparam op_t OP_NOR  = 3'b011;
    localparam op_t OP_XOR  = 3'b100;
    localparam op_t OP_XNOR = 3'b101;
    localparam op_t OP_NOTA = 3'b110;
    localparam op_t OP_PASS = 3'b111;

endpackage : logic_unit_pipe_pkg
`default_nettype wire

// File: rtl/logic_unit_pipe_fn.sv
`default_nettype none
// ============================================================================
// Module   : logic_fn
// Purpose  : Combinational eight-way bitwise function of A and effective B.
// Revision : 1.0
// ============================================================================
module logic_fn
    import logic_unit_pipe_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [2:0]   i_op,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_f
);

    always_comb begin
        o_f = '0;
        case (op_t'(i_op))
            OP_AND:  o_f = i_a & i_b;
            OP_NAND: o_f = ~(i_a & i_b);
            OP_OR:   o_f = i_a | i_b;
            OP_NOR:  o_f = ~(i_a | i_b);
            OP_XOR:  o_f = i_a ^ i_b;
            OP_XNOR: o_f = ~(i_a ^ i_b);
            OP_NOTA: o_f = ~i_a;
            OP_PASS: o_f = i_a;
            default: o_f = '0;
        endcase
    end

endmodule : logic_fn
`default_nettype wire

// File: rtl/logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : logic_unit_pipe
// Purpose  : Registered logic unit with accumulator, valid/ready output stage,
//            zero flag and saturating operation counter.
// Revision : 1.0
// ============================================================================
module logic_unit_pipe
    import logic_unit_pipe_pkg::*;
#(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [2:0]       op,
    input  logic             acc_en,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     s,
    output logic             zero,
    output logic [W-1:0]     acc,
    output logic [CNT_W-1:0] op_count
);

    logic             r_out_valid;
    logic [W-1:0]     r_s;
    logic             r_zero;
    logic [W-1:0]     r_acc;
    logic [CNT_W-1:0] r_op_count;

    logic             w_xfer;
    logic [W-1:0]     w_b_eff;
    logic [W-1:0]     w_f;

    // Output slot is free when empty or being drained this cycle.
    assign in_ready = !r_out_valid || out_ready;
    assign w_xfer   = in_valid && in_ready;

    always_comb begin
        w_b_eff = b;
        if (acc_en) begin
            w_b_eff = acc_clr ? '0 : r_acc;
        end
    end

    logic_fn #(
        .W (W)
    ) u_logic_fn (
        .i_op (op),
        .i_a  (a),
        .i_b  (w_b_eff),
        .o_f  (w_f)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_s         <= '0;
            r_zero      <= 1'b1;
            r_acc       <= '0;
            r_op_count  <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_s         <= w_f;
            r_zero      <= (w_f == '0);
            if (acc_en) begin
                r_acc <= w_f;
            end
            if (r_op_count != {CNT_W{1'b1}}) begin
                r_op_count <= r_op_count + CNT_W'(1);
            end
        end else if (out_ready) begin
            // Drain without replacement; result and flag keep their last value.
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign s         = r_s;
    assign zero      = r_zero;
    assign acc       = r_acc;
    assign op_count  = r_op_count;

endmodule : logic_unit_pipe
`default_nettype wire

// File: tb/tb_logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_unit_pipe
// Purpose  : Directed self-checking bench for logic_unit_pipe (W=4, CNT_W=2).
// Revision : 1.0
// ============================================================================
module tb_logic_unit_pipe;

    localparam int W     = 4;
    localparam int CNT_W = 2;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [2:0]       op;
    logic             acc_en;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     s;
    logic             zero;
    logic [W-1:0]     acc;
    logic [CNT_W-1:0] op_count;

    int n_pass;
    int n_total;

    logic_unit_pipe #(
        .W     (W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .acc_en    (acc_en),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .zero      (zero),
        .acc       (acc),
        .op_count  (op_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        n_total++;
        assert (observed === expected) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_out_valid"}, 8'(out_valid), 8'h0);
        chk({tag, "_s"},         8'(s),         8'h0);
        chk({tag, "_zero"},      8'(zero),      8'h1);
        chk({tag, "_acc"},       8'(acc),       8'h0);
        chk({tag, "_op_count"},  8'(op_count),  8'h0);
    endtask

    // One transfer with out_ready=1; outputs observed 1 time unit after the edge.
    task automatic send(input logic [3:0] ta, input logic [3:0] tb, input logic [2:0] top,
                        input logic ten, input logic tclr);
        @(negedge clk);
        a        = ta;
        b        = tb;
        op       = top;
        acc_en   = ten;
        acc_clr  = tclr;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        op        = '0;
        acc_en    = 1'b0;
        acc_clr   = 1'b0;

        #1;
        chk_reset("reset");
        chk("reset_in_ready", 8'(in_ready), 8'h1);
        @(negedge clk);
        rst = 1'b0;

        // Legacy table: bit columns of a=0011, b=0101 cover all four (a,b) pairs.
        send(4'b0011, 4'b0101, 3'b000, 1'b0, 1'b0);
        chk("legacy_and", 8'(s), 8'h1);
        chk("legacy_and_valid", 8'(out_valid), 8'h1);
        send(4'b0011, 4'b0101, 3'b001, 1'b0, 1'b0);
        chk("legacy_nand", 8'(s), 8'hE);
        send(4'b0011, 4'b0101, 3'b010, 1'b0, 1'b0);
        chk("legacy_or", 8'(s), 8'h7);
        send(4'b0011, 4'b0101, 3'b011, 1'b0, 1'b0);
        chk("legacy_nor", 8'(s), 8'h8);

        send(4'b1100, 4'b1010, 3'b100, 1'b0, 1'b0);
        chk("xor_s", 8'(s), 8'h6);
        chk("xor_zero", 8'(zero), 8'h0);
        send(4'b1100, 4'b1010, 3'b101, 1'b0, 1'b0);
        chk("xnor_s", 8'(s), 8'h9);
        send(4'b1100, 4'b1010, 3'b110, 1'b0, 1'b0);
        chk("nota_s", 8'(s), 8'h3);
        send(4'b1100, 4'b1010, 3'b111, 1'b0, 1'b0);
        chk("pass_s", 8'(s), 8'hC);
        send(4'b0101, 4'b1010, 3'b000, 1'b0, 1'b0);
        chk("and_zero_s", 8'(s), 8'h0);
        chk("and_zero_flag", 8'(zero), 8'h1);
        chk("acc_untouched", 8'(acc), 8'h0);

        @(posedge clk);
        #1;
        chk("drain_valid", 8'(out_valid), 8'h0);
        chk("drain_s_held", 8'(s), 8'h0);
        chk("drain_zero_held", 8'(zero), 8'h1);

        send(4'b0011, 4'b1111, 3'b010, 1'b1, 1'b1);
        chk("acc_clr_or_acc", 8'(acc), 8'h3);
        chk("acc_clr_or_s", 8'(s), 8'h3);
        send(4'b0101, 4'b1111, 3'b100, 1'b1, 1'b0);
        chk("acc_xor_s", 8'(s), 8'h6);
        chk("acc_xor_acc", 8'(acc), 8'h6);
        send(4'b1111, 4'b0000, 3'b000, 1'b0, 1'b1);
        chk("acc_off_s", 8'(s), 8'h0);
        chk("acc_off_acc", 8'(acc), 8'h6);

        pulse_reset();
        send(4'b1100, 4'b1010, 3'b100, 1'b0, 1'b0);
        chk("bp_first_s", 8'(s), 8'h6);
        chk("bp_first_cnt", 8'(op_count), 8'h1);
        @(negedge clk);
        out_ready = 1'b0;
        a         = 4'b0000;
        b         = 4'b1111;
        op        = 3'b010;
        acc_en    = 1'b0;
        acc_clr   = 1'b0;
        in_valid  = 1'b1;
        #1;
        chk("bp_in_ready_low", 8'(in_ready), 8'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp_hold_s_%0d", i), 8'(s), 8'h6);
            chk($sformatf("bp_hold_cnt_%0d", i), 8'(op_count), 8'h1);
            chk($sformatf("bp_hold_valid_%0d", i), 8'(out_valid), 8'h1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_high", 8'(in_ready), 8'h1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_replace_s", 8'(s), 8'hF);
        chk("bp_replace_valid", 8'(out_valid), 8'h1);
        chk("bp_replace_cnt", 8'(op_count), 8'h2);
        chk("bp_replace_zero", 8'(zero), 8'h0);

        pulse_reset();
        send(4'b0001, 4'b0001, 3'b010, 1'b0, 1'b0);
        chk("sat_1", 8'(op_count), 8'h1);
        send(4'b0001, 4'b0001, 3'b010, 1'b0, 1'b0);
        chk("sat_2", 8'(op_count), 8'h2);
        send(4'b0001, 4'b0001, 3'b010, 1'b0, 1'b0);
        chk("sat_3", 8'(op_count), 8'h3);
        send(4'b0001, 4'b0001, 3'b010, 1'b0, 1'b0);
        chk("sat_4", 8'(op_count), 8'h3);
        send(4'b0101, 4'b0000, 3'b010, 1'b1, 1'b1);
        chk("sat_5", 8'(op_count), 8'h3);
        chk("pre_rst_acc", 8'(acc), 8'h5);
        chk("pre_rst_valid", 8'(out_valid), 8'h1);

        // Reset raised and observed between clock edges.
        #2;
        rst = 1'b1;
        #1;
        chk_reset("async_rst");
        rst = 1'b0;
        send(4'b1010, 4'b0101, 3'b010, 1'b0, 1'b0);
        chk("post_rst_s", 8'(s), 8'hF);
        chk("post_rst_valid", 8'(out_valid), 8'h1);
        chk("post_rst_cnt", 8'(op_count), 8'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_logic_unit_pipe
`default_nettype wire
